alarm_controller: RTL and testbench
===================================

// Module: alarm_controller
// PURPOSE
//  Consumes the BCD HHMMSS time from the 24-hour timekeeper on the same 1 Hz CLK.
//  Holds a programmable HH:MM alarm and raises Ringing when the time reaches HH:MM:00.
//  Supports snooze (re-arm SNOOZE_MIN minutes later, 24 h wrap), Stop, and ring timeout.
//  Drives the buzzer/LED stage downstream.
// PARAMETERS
//  SNOOZE_MIN     9        snooze interval in minutes, 1..59
//  RING_SEC       60       CLK cycles an untouched alarm rings before auto-stop, >=1
//  MAX_SNOOZE     3        snoozes allowed per alarm event, 1..3
//  ALARM_DEFAULT  16'h0700 BCD HHMM loaded into Alarm_time on Reset
// PORTS
//  CLK           in   1   clock; one timekeeper second per cycle
//  Reset         in   1   synchronous, active-high
//  Time_in       in   24  BCD {HH,MM,SS} from timekeeper Time_out
//  Set_alarm     in   1   load Alarm_in this cycle
//  Alarm_in      in   16  BCD {HH,MM} new alarm time
//  Alarm_enable  in   1   level; alarm armed while high
//  Snooze        in   1   request snooze (sampled each cycle)
//  Stop          in   1   dismiss alarm (sampled each cycle)
//  Alarm_time    out  16  stored alarm HHMM
//  Ringing       out  1   high in RING
//  Snoozing      out  1   high in SNOOZE
//  Snooze_count  out  2   snoozes used in current event
//  Missed        out  1   sticky: ring timed out without Stop/Snooze
//  Set_error     out  1   one-cycle pulse: Alarm_in rejected
// BEHAVIOUR
//  Reset: Alarm_time=ALARM_DEFAULT; all other outputs 0; state IDLE; match_q=0; target=ALARM_DEFAULT.
//  match(t) = (Time_in[23:8]==t) && (Time_in[7:0]==8'h00).
//  hit      = match & ~match_q; match_q is registered each cycle.
//  A Time_in held at HH:MM:00 (Set_time) therefore fires once only.
//  All outputs are registered. Ringing/Snoozing change the cycle after the causing input.
//  States: IDLE, RING, SNOOZE. Priority: Reset > ~Alarm_enable > Set_alarm > Stop > Snooze > hit/timeout.
//   IDLE:   Alarm_enable & hit(Alarm_time) -> RING; target=Alarm_time, ring_cnt=0, Snooze_count=0.
//   RING:   Stop -> IDLE, Snooze_count=0.
//           Snooze & Snooze_count<MAX_SNOOZE -> SNOOZE; target=target+SNOOZE_MIN, Snooze_count++.
//           Snooze with Snooze_count==MAX_SNOOZE is ignored; ringing continues.
//           ring_cnt==RING_SEC-1 -> IDLE, Missed=1, Snooze_count=0. Ringing lasts exactly RING_SEC cycles.
//   SNOOZE: Stop -> IDLE, Snooze_count=0.
//           hit(target) -> RING, ring_cnt=0.
//  ~Alarm_enable in any state -> IDLE, Snooze_count=0. Missed is preserved.
//  Set_alarm: Alarm_in is valid iff HH<=23, MM<=59, every digit<=9.
//   Valid:   Alarm_time<=Alarm_in. If RING/SNOOZE -> IDLE, Snooze_count=0.
//   Invalid: Alarm_time and state unchanged; Set_error=1 for one cycle.
//  Missed clears on Stop or on a valid Set_alarm.
//  Snooze arithmetic: BCD minutes add with carry into hours; 23:5x+9 wraps to 00:0y.
//   Digits stay in legal BCD at all times.
//  Time_in is trusted as legal BCD and is not checked.
// STRUCTURE
//  clock_pkg: BCD digit and HHMM typedefs, state enum, constants HH_MAX=23, MM_MAX=59.
//  Sub-module bcd_hhmm_add: combinational HHMM + minutes (0..59) with 24 h wrap; reused by the timekeeper.
// TESTING
//  1. Alarm 07:00, enable, Time_in 06:59:58..07:00:02 -> Ringing=1 the cycle after 07:00:00.
//  2. Ringing, Snooze at 07:00:05 -> Snoozing=1, Snooze_count=1; Ringing again the cycle after 07:09:00.
//  3. Alarm 23:55, Snooze -> rings the cycle after 00:04:00 (wrap across midnight).
//  4. No input for 60 cycles of ringing -> Ringing falls after exactly 60 cycles, Missed=1; Stop -> Missed=0.
//  5a. 3 snoozes, then 4th Snooze -> ignored, Ringing stays 1, Snooze_count=3.
//  5b. Stop and Snooze in the same cycle -> IDLE, Snooze_count=0.
//  6a. Set_alarm 16'h2460 -> Set_error pulse, Alarm_time unchanged.
//  6b. Time_in held at 07:00:00 for 5 cycles -> exactly one RING entry.
//  6c. Reset mid-RING -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared BCD clock types, alarm FSM states and BCD helper functions.
package clock_pkg;

    localparam int unsigned HH_MAX = 23;
    localparam int unsigned MM_MAX = 59;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t h1;
        bcd_digit_t h0;
        bcd_digit_t m1;
        bcd_digit_t m0;
    } hhmm_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_t;

    // Two BCD digits to binary (0..99).
    function automatic logic [6:0] bcd2_to_bin(input bcd_digit_t tens, input bcd_digit_t ones);
        return 7'({3'b000, tens}) * 7'd10 + 7'({3'b000, ones});
    endfunction

    // Binary 0..99 to two BCD digits.
    function automatic logic [7:0] bin_to_bcd2(input logic [6:0] value);
        logic [6:0] tens;
        logic [6:0] ones;
        tens = value / 7'd10;
        ones = value - tens * 7'd10;
        return {tens[3:0], ones[3:0]};
    endfunction

    // Legal alarm time: every digit 0..9, hours 0..23, minutes 0..59.
    function automatic logic hhmm_valid(input hhmm_t t);
        logic digits_ok;
        digits_ok = (t.h1 <= 4'd9) && (t.h0 <= 4'd9) && (t.m1 <= 4'd9) && (t.m0 <= 4'd9);
        return digits_ok
            && (bcd2_to_bin(t.h1, t.h0) <= 7'(HH_MAX))
            && (bcd2_to_bin(t.m1, t.m0) <= 7'(MM_MAX));
    endfunction

endpackage

// File: rtl/bcd_hhmm_add.sv
// Combinational BCD HH:MM plus 0..59 minutes, wrapping at 24 hours.
module bcd_hhmm_add
    import clock_pkg::*;
(
    input  logic [15:0] hhmm,
    input  logic [5:0]  add_min,
    output logic [15:0] sum_c
);

    hhmm_t      t;
    logic [6:0] hh_bin;
    logic [6:0] mm_bin;
    logic [6:0] mm_raw;
    logic [6:0] mm_out;
    logic [6:0] hh_inc;
    logic [6:0] hh_out;

    // Binary add with minute carry into hours and midnight wrap, then back to BCD.
    always_comb begin
        t      = hhmm_t'(hhmm);
        hh_bin = bcd2_to_bin(t.h1, t.h0);
        mm_bin = bcd2_to_bin(t.m1, t.m0);
        mm_raw = mm_bin + 7'(add_min);
        mm_out = mm_raw;
        hh_inc = hh_bin;
        if (mm_raw > 7'(MM_MAX)) begin
            mm_out = mm_raw - 7'(MM_MAX + 1);
            hh_inc = hh_bin + 7'd1;
        end
        hh_out = hh_inc;
        if (hh_inc > 7'(HH_MAX)) begin
            hh_out = hh_inc - 7'(HH_MAX + 1);
        end
        sum_c = {bin_to_bcd2(hh_out), bin_to_bcd2(mm_out)};
    end

endmodule

// File: rtl/alarm_controller.sv
// Programmable HH:MM alarm with snooze, stop and ring timeout, clocked at 1 Hz.
module alarm_controller
    import clock_pkg::*;
#(
    parameter int unsigned SNOOZE_MIN    = 9,
    parameter int unsigned RING_SEC      = 60,
    parameter int unsigned MAX_SNOOZE    = 3,
    parameter logic [15:0] ALARM_DEFAULT = 16'h0700
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [23:0] Time_in,
    input  logic        Set_alarm,
    input  logic [15:0] Alarm_in,
    input  logic        Alarm_enable,
    input  logic        Snooze,
    input  logic        Stop,
    output logic [15:0] Alarm_time,
    output logic        Ringing,
    output logic        Snoozing,
    output logic [1:0]  Snooze_count,
    output logic        Missed,
    output logic        Set_error
);

    localparam int unsigned CNT_W = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;

    alarm_state_t state, state_n;
    logic [15:0]  target, target_n;
    logic [15:0]  alarm_n;
    logic [15:0]  snooze_target;
    logic [15:0]  cmp_time;
    logic [CNT_W-1:0] ring_cnt, ring_cnt_n;
    logic [1:0]   snooze_count_n;
    logic         match_q, match, hit;
    logic         missed_n, set_error_n, set_valid;

    bcd_hhmm_add u_snooze_add (
        .hhmm    (target),
        .add_min (6'(SNOOZE_MIN)),
        .sum_c   (snooze_target)
    );

    // Next-state and output decode; priority enable > set > stop > snooze > hit/timeout.
    always_comb begin
        state_n        = state;
        target_n       = target;
        alarm_n        = Alarm_time;
        ring_cnt_n     = ring_cnt;
        snooze_count_n = Snooze_count;
        missed_n       = Missed;
        set_error_n    = 1'b0;

        cmp_time  = (state == SNOOZE) ? target : Alarm_time;
        match     = (Time_in[23:8] == cmp_time) && (Time_in[7:0] == 8'h00);
        hit       = match && !match_q;
        set_valid = hhmm_valid(hhmm_t'(Alarm_in));

        if (Set_alarm) begin
            if (set_valid) begin
                alarm_n  = Alarm_in;
                missed_n = 1'b0;
            end else begin
                set_error_n = 1'b1;
            end
        end

        if (!Alarm_enable) begin
            state_n        = IDLE;
            snooze_count_n = 2'd0;
        end else if (Set_alarm) begin
            if (set_valid) begin
                state_n        = IDLE;
                snooze_count_n = 2'd0;
            end
        end else if (Stop) begin
            state_n        = IDLE;
            snooze_count_n = 2'd0;
            missed_n       = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        state_n        = RING;
                        target_n       = Alarm_time;
                        ring_cnt_n     = '0;
                        snooze_count_n = 2'd0;
                    end
                end
                RING: begin
                    if (Snooze && (Snooze_count < 2'(MAX_SNOOZE))) begin
                        state_n        = SNOOZE;
                        target_n       = snooze_target;
                        snooze_count_n = Snooze_count + 2'd1;
                    end else if (ring_cnt == CNT_W'(RING_SEC - 1)) begin
                        state_n        = IDLE;
                        missed_n       = 1'b1;
                        snooze_count_n = 2'd0;
                    end else begin
                        ring_cnt_n = ring_cnt + CNT_W'(1);
                    end
                end
                SNOOZE: begin
                    if (hit) begin
                        state_n    = RING;
                        ring_cnt_n = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state        <= IDLE;
            Alarm_time   <= ALARM_DEFAULT;
            target       <= ALARM_DEFAULT;
            match_q      <= 1'b0;
            ring_cnt     <= '0;
            Snooze_count <= 2'd0;
            Missed       <= 1'b0;
            Set_error    <= 1'b0;
            Ringing      <= 1'b0;
            Snoozing     <= 1'b0;
        end else begin
            state        <= state_n;
            Alarm_time   <= alarm_n;
            target       <= target_n;
            match_q      <= match;
            ring_cnt     <= ring_cnt_n;
            Snooze_count <= snooze_count_n;
            Missed       <= missed_n;
            Set_error    <= set_error_n;
            Ringing      <= (state_n == RING);
            Snoozing     <= (state_n == SNOOZE);
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with a seconds-of-day reference model.
module tb_alarm_controller;

    localparam int SNOOZE_MIN = 9;
    localparam int RING_SEC   = 60;
    localparam int MAX_SNOOZE = 3;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [23:0] Time_in = '0;
    logic        Set_alarm = 1'b0;
    logic [15:0] Alarm_in = '0;
    logic        Alarm_enable = 1'b0;
    logic        Snooze = 1'b0;
    logic        Stop = 1'b0;
    logic [15:0] Alarm_time;
    logic        Ringing, Snoozing, Missed, Set_error;
    logic [1:0]  Snooze_count;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;
    int now = 0;

    alarm_controller #(
        .SNOOZE_MIN(SNOOZE_MIN), .RING_SEC(RING_SEC),
        .MAX_SNOOZE(MAX_SNOOZE), .ALARM_DEFAULT(16'h0700)
    ) dut (
        .CLK(CLK), .Reset(Reset), .Time_in(Time_in), .Set_alarm(Set_alarm),
        .Alarm_in(Alarm_in), .Alarm_enable(Alarm_enable), .Snooze(Snooze), .Stop(Stop),
        .Alarm_time(Alarm_time), .Ringing(Ringing), .Snoozing(Snoozing),
        .Snooze_count(Snooze_count), .Missed(Missed), .Set_error(Set_error)
    );

    always #5 CLK = ~CLK;

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, x;
        h = s / 3600; m = (s / 60) % 60; x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic int hhmm_minutes(input logic [15:0] a);
        return (int'(a[15:12]) * 10 + int'(a[11:8])) * 60 + int'(a[7:4]) * 10 + int'(a[3:0]);
    endfunction

    function automatic int time_secs(input logic [23:0] t);
        return hhmm_minutes(t[23:8]) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
    endfunction

    function automatic bit legal_alarm(input logic [15:0] a);
        if (a[15:12] > 9 || a[11:8] > 9 || a[7:4] > 9 || a[3:0] > 9) return 1'b0;
        return (int'(a[15:12]) * 10 + int'(a[11:8]) <= 23) && (int'(a[7:4]) * 10 + int'(a[3:0]) <= 59);
    endfunction

    // Reference model: alarm and snooze target held as minutes of the day.
    logic [15:0] m_alarm = 16'h0700;
    int  m_target = 420;
    bit  m_ring = 0, m_snz = 0, m_missed = 0, m_err = 0, m_prev = 0;
    int  m_elapsed = 0, m_sc = 0;

    always @(posedge CLK) begin
        int  cmp_min;
        bit  mt, ht, ok;
        cmp_min = m_snz ? m_target : hhmm_minutes(m_alarm);
        mt = (time_secs(Time_in) == cmp_min * 60);
        ht = mt && !m_prev;
        if (Reset) begin
            m_alarm = 16'h0700; m_target = 420; m_ring = 0; m_snz = 0;
            m_missed = 0; m_err = 0; m_prev = 0; m_elapsed = 0; m_sc = 0;
        end else begin
            m_prev = mt;
            m_err  = 0;
            ok = legal_alarm(Alarm_in);
            if (Set_alarm) begin
                if (ok) begin m_alarm = Alarm_in; m_missed = 0; end
                else m_err = 1;
            end
            if (!Alarm_enable) begin
                m_ring = 0; m_snz = 0; m_sc = 0;
            end else if (Set_alarm) begin
                if (ok) begin m_ring = 0; m_snz = 0; m_sc = 0; end
            end else if (Stop) begin
                m_ring = 0; m_snz = 0; m_sc = 0; m_missed = 0;
            end else if (m_ring) begin
                if (Snooze && m_sc < MAX_SNOOZE) begin
                    m_ring = 0; m_snz = 1; m_sc++;
                    m_target = (m_target + SNOOZE_MIN) % 1440;
                end else if (m_elapsed + 1 == RING_SEC) begin
                    m_ring = 0; m_missed = 1; m_sc = 0;
                end else begin
                    m_elapsed++;
                end
            end else if (m_snz) begin
                if (ht) begin m_snz = 0; m_ring = 1; m_elapsed = 0; end
            end else if (ht) begin
                m_ring = 1; m_elapsed = 0; m_sc = 0; m_target = hhmm_minutes(m_alarm);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (check_en) begin
            chk("alarm_time",   32'(Alarm_time),   32'(m_alarm));
            chk("ringing",      32'(Ringing),      32'(m_ring));
            chk("snoozing",     32'(Snoozing),     32'(m_snz));
            chk("snooze_count", 32'(Snooze_count), 32'(m_sc));
            chk("missed",       32'(Missed),       32'(m_missed));
            chk("set_error",    32'(Set_error),    32'(m_err));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            Time_in = to_bcd(now);
            tick();
            now = (now + 1) % 86400;
        end
    endtask

    task automatic set_alarm(input logic [15:0] a);
        Set_alarm = 1'b1; Alarm_in = a;
        adv(1);
        Set_alarm = 1'b0;
    endtask

    task automatic pulse_snooze();
        Snooze = 1'b1; adv(1); Snooze = 1'b0;
    endtask

    task automatic pulse_stop();
        Stop = 1'b1; adv(1); Stop = 1'b0;
    endtask

    initial begin
        now = 6 * 3600 + 59 * 60 + 50;
        adv(2);
        chk("reset_alarm_time", 32'(Alarm_time), 32'h0700);
        chk("reset_ringing", 32'(Ringing), 32'd0);
        Reset = 1'b0;
        check_en = 1'b1;
        Alarm_enable = 1'b1;

        // 1: ring the cycle after 07:00:00
        now = 6 * 3600 + 59 * 60 + 58;
        adv(2);
        chk("t1_before", 32'(Ringing), 32'd0);
        adv(1);
        chk("t1_ring", 32'(Ringing), 32'd1);
        adv(4);

        // 2: snooze at 07:00:05, re-ring after 07:09:00
        pulse_snooze();
        chk("t2_snoozing", 32'(Snoozing), 32'd1);
        chk("t2_count", 32'(Snooze_count), 32'd1);
        now = 7 * 3600 + 8 * 60 + 58;
        adv(2);
        chk("t2_quiet", 32'(Ringing), 32'd0);
        adv(1);
        chk("t2_rering", 32'(Ringing), 32'd1);
        pulse_stop();
        chk("t2_stop", 32'(Snooze_count), 32'd0);

        // 4: timeout after exactly RING_SEC cycles, Stop clears Missed
        set_alarm(16'h0730);
        now = 7 * 3600 + 29 * 60 + 59;
        adv(2);
        adv(RING_SEC - 1);
        chk("t4_last_ring", 32'(Ringing), 32'd1);
        adv(1);
        chk("t4_timeout", 32'(Ringing), 32'd0);
        chk("t4_missed", 32'(Missed), 32'd1);
        pulse_stop();
        chk("t4_missed_clr", 32'(Missed), 32'd0);

        // 5a: three snoozes then a fourth is ignored
        now = 7 * 3600 + 29 * 60 + 59;
        adv(2);
        for (int k = 1; k <= 3; k++) begin
            pulse_snooze();
            chk("t5_count", 32'(Snooze_count), 32'(k));
            now = 7 * 3600 + (30 + 9 * k) * 60 - 1;
            adv(2);
            chk("t5_rering", 32'(Ringing), 32'd1);
        end
        pulse_snooze();
        chk("t5_ignored_ring", 32'(Ringing), 32'd1);
        chk("t5_ignored_cnt", 32'(Snooze_count), 32'd3);

        // 5b: Stop wins over Snooze in the same cycle
        Stop = 1'b1; Snooze = 1'b1; adv(1); Stop = 1'b0; Snooze = 1'b0;
        chk("t5b_ring", 32'(Ringing), 32'd0);
        chk("t5b_cnt", 32'(Snooze_count), 32'd0);

        // 3: 23:55 + 9 min wraps to 00:04
        set_alarm(16'h2355);
        now = 23 * 3600 + 55 * 60 - 1;
        adv(2);
        chk("t3_ring", 32'(Ringing), 32'd1);
        pulse_snooze();
        now = 4 * 60 - 1;
        adv(1);
        chk("t3_quiet", 32'(Ringing), 32'd0);
        adv(1);
        chk("t3_wrap_ring", 32'(Ringing), 32'd1);
        pulse_stop();

        // 6a: illegal alarm rejected
        set_alarm(16'h2460);
        chk("t6a_err", 32'(Set_error), 32'd1);
        chk("t6a_keep", 32'(Alarm_time), 32'h2355);
        adv(1);
        chk("t6a_pulse", 32'(Set_error), 32'd0);

        // 6b: time held at 07:00:00 fires only once
        set_alarm(16'h0700);
        now = 7 * 3600 - 1;
        adv(1);
        Time_in = to_bcd(7 * 3600);
        repeat (5) tick();
        chk("t6b_ring", 32'(Ringing), 32'd1);
        Stop = 1'b1; tick(); Stop = 1'b0;
        repeat (3) tick();
        chk("t6b_once", 32'(Ringing), 32'd0);

        // 6c: reset mid-ring
        set_alarm(16'h0701);
        now = 7 * 3600 + 60 - 1;
        adv(2);
        chk("t6c_ring", 32'(Ringing), 32'd1);
        Reset = 1'b1; adv(1); Reset = 1'b0;
        chk("t6c_ring0", 32'(Ringing), 32'd0);
        chk("t6c_alarm", 32'(Alarm_time), 32'h0700);
        adv(3);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
